// File: rtl/ysyx_23060096_pkg.sv
// Shared IFU definitions: fetch FSM state encodings, default boot address,
// counter width and a word-alignment helper.
package ysyx_23060096_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int          PERF_CNT_W   = 32;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060096_perf_cnt.sv
// Free-running event counter: +1 on each cycle i_inc is high, wraps at 2^32.
// Output is the registered count; no backpressure.
module ysyx_23060096_perf_cnt
  import ysyx_23060096_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_inc,
  output logic [PERF_CNT_W-1:0] o_cnt
);

  logic [PERF_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: one outstanding request, REQ/WAIT/HOLD (3 cycles min), held until decode takes it.
// Optional counters under YSYX_23060096_IFU_PERF_EN.
module ysyx_23060096_ifu
  import ysyx_23060096_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef YSYX_23060096_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  ifu_state_e  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic        r_req_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_inst_valid;
  logic        r_stale;

  logic [31:0] w_redir_pc;
  logic [31:0] w_refetch_pc;
  logic [31:0] w_next_pc;

  assign w_redir_pc   = word_align(redirect_pc);
  assign w_refetch_pc = redirect_valid ? w_redir_pc : r_fetch_pc;
  assign w_next_pc    = redirect_valid ? w_redir_pc : r_fetch_pc + 32'd4;

  // r_req_addr is separate from r_fetch_pc so a redirect cannot move a request still waiting for ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IFU_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_inst       <= 32'd0;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_stale      <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
      end
      case (r_state)
        IFU_IDLE: begin
          r_state     <= IFU_REQ;
          r_req_valid <= 1'b1;
          r_req_addr  <= w_refetch_pc;
        end
        IFU_REQ: begin
          if (redirect_valid) begin
            r_stale <= 1'b1;
          end
          if (imem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            // A redirect arriving with the response makes that response stale too.
            if (r_stale || redirect_valid) begin
              r_stale     <= 1'b0;
              r_state     <= IFU_REQ;
              r_req_valid <= 1'b1;
              r_req_addr  <= w_refetch_pc;
            end else begin
              r_inst       <= imem_rsp_data;
              r_pc         <= r_fetch_pc;
              r_inst_valid <= 1'b1;
              r_state      <= IFU_HOLD;
            end
          end else if (redirect_valid) begin
            r_stale <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (inst_ready || redirect_valid) begin
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= w_next_pc;
            r_req_addr   <= w_next_pc;
            r_req_valid  <= 1'b1;
            r_state      <= IFU_REQ;
          end
        end
        default: begin
          r_state <= IFU_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign pc             = r_pc;

`ifdef YSYX_23060096_IFU_PERF_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = r_inst_valid & inst_ready;
  assign w_stall_inc = (r_state == IFU_WAIT);

  ysyx_23060096_perf_cnt u_fetch_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_fetch_inc),
    .o_cnt (perf_fetch_cnt)
  );

  ysyx_23060096_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_stall_inc),
    .o_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: doc/ysyx_23060096_ifu.md
YSYX_23060096_IFU -- requirements
Module: ysyx_23060096_ifu

Interface
REQ-001 RESET_PC, 32'h8000_0000, address of the first fetch after reset SHALL be a parameter.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  32  fetch address, word-aligned.
REQ-007 imem_rsp_valid  input  1  read data valid, single-cycle pulse.
REQ-008 imem_rsp_data  input  32  instruction word.
REQ-009 inst_valid  output  1  instruction available to decode.
REQ-010 inst_ready  input  1  decode consumes instruction.
REQ-011 inst  output  32  instruction word to decode.
REQ-012 pc  output  32  address of inst.
REQ-013 redirect_valid  input  1  branch/jump target valid, single-cycle pulse.
REQ-014 redirect_pc  input  32  next fetch address.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, HOLD; IDLE -> REQ unconditionally one cycle after reset release.
REQ-016 REQ: imem_req_valid=1, imem_req_addr=fetch_pc; on imem_req_ready=1 -> WAIT.
REQ-017 imem_req_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-018 WAIT: on imem_rsp_valid=1 with stale=0, latch inst=imem_rsp_data and pc=fetch_pc -> HOLD.
REQ-019 HOLD: inst_valid=1; inst/pc SHALL stay stable until inst_ready=1, then fetch_pc<=fetch_pc+4 -> REQ.
REQ-020 Minimum latency SHALL be 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory.
REQ-021 redirect_valid in any state SHALL load fetch_pc<=redirect_pc with bits [1:0] forced to 0; this redirect takes priority over the +4 increment.
REQ-022 Redirect in REQ or WAIT SHALL set stale=1; the matching response SHALL be discarded, stale cleared, and the FSM SHALL go to REQ at the redirected address.
REQ-023 Redirect in HOLD without inst_ready SHALL drop the held instruction (inst_valid=0 next cycle) and go to REQ.
REQ-024 Redirect and inst_valid&inst_ready in the same cycle: transfer completes, next fetch SHALL use redirect_pc.
REQ-025 imem_rsp_valid in IDLE, REQ or HOLD SHALL be ignored.
REQ-026 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-027 On rstn=0: state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst=0, stale=0, imem_req_valid=0, inst_valid=0, immediately and asynchronously.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; any late response SHALL be ignored (REQ-025).

Configuration
REQ-029 With YSYX_23060096_IFU_PERF_EN defined: outputs perf_fetch_cnt[31:0] (increments on each inst_valid&inst_ready) and perf_stall_cnt[31:0] (increments each cycle in WAIT) SHALL exist, reset to 0, wrap at 2^32.
REQ-030 Without YSYX_23060096_IFU_PERF_EN: these ports and counters SHALL be absent; behaviour otherwise identical.

Structure
REQ-031 FSM state encodings and the default RESET_PC value SHALL live in the shared ysyx_23060096 defines package.
REQ-032 The performance counters SHALL be one sub-module, ysyx_23060096_perf_cnt, instantiated twice under the macro.

Verification
REQ-033 Reset release, ready=1, rsp one cycle after accept -> first imem_req_addr=32'h8000_0000, inst_valid on cycle 3, pc=32'h8000_0000.
REQ-034 inst_ready=0 for 5 cycles in HOLD -> inst/pc stable, no new request; ready=1 -> next req addr 32'h8000_0004.
REQ-035 redirect_pc=32'h8000_0103 during WAIT -> response discarded, next req addr 32'h8000_0100, stale cleared.
REQ-036 imem_req_ready=0 for 4 cycles -> addr stable; redirect in cycle 2 -> eventual response dropped, refetch at target.
REQ-037 fetch_pc=32'hFFFF_FFFC consumed -> next req addr 32'h0000_0000.
REQ-038 rstn asserted in WAIT, response arrives after release -> ignored, fetch restarts at RESET_PC; with PERF_EN counters read 0.
